instr_enc: RTL

Instruction encoder: the write-side counterpart of `instr_dec`. It takes one decoded MSP430 instruction description per handshake (format, opcode, registers, addressing modes, extension words) and packs it into the 16-bit word stream that `instr_dec` consumes. It writes those words into program memory over a MAB/MDB write port, inserting source and destination extension words exactly where the decoder expects them. It sits between the program loader/bench and program memory.

---
 rtl/instr_enc.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instr_enc.sv
// MSP430 instruction encoder: packs one decoded instruction per handshake into
// the 16-bit word stream expected by instr_dec and writes it to program memory.
module instr_enc #(
    parameter logic [15:0] START_ADDR = 16'hC000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_addr,
    input  logic [15:0] addr_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  fmt,
    input  logic [3:0]  opcode,
    input  logic [2:0]  op2,
    input  logic [2:0]  cond,
    input  logic [9:0]  offset,
    input  logic [3:0]  src,
    input  logic [3:0]  dst,
    input  logic [1:0]  as,
    input  logic        ad,
    input  logic        bw,
    input  logic [15:0] src_ext,
    input  logic [15:0] dst_ext,
    output logic [15:0] MAB_out,
    output logic [15:0] MDB_in,
    output logic        MW,
    input  logic        mem_ready,
    output logic [1:0]  nwords,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INSTR = 2'd1,
        S_SRCX  = 2'd2,
        S_DSTX  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_addr;
    logic [15:0] r_mdb;
    logic        r_mw;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_nwords;
    logic        r_sx;
    logic        r_dx;
    logic [15:0] r_src_ext;
    logic [15:0] r_dst_ext;

    logic [3:0]  w_sreg;
    logic        w_illegal;
    logic        w_sx;
    logic        w_dx;
    logic [15:0] w_word0;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_accept_ok;
    logic        w_final;
    logic [15:0] w_mdb_next;

    // Request decode: legality, extension-word needs and word 0 packing
    always_comb begin
        w_sreg    = (fmt == 2'd1) ? src : dst;
        w_illegal = (fmt == 2'd0)
                  || ((fmt == 2'd1) && (opcode < 4'd4))
                  || ((fmt == 2'd2) && (op2 == 3'd7));
        // R3 never takes an extension word (constant generator); R0 with @PC+ is immediate
        w_sx      = (fmt != 2'd3)
                  && (((as == 2'b01) && (w_sreg != 4'd3))
                   || ((as == 2'b11) && (w_sreg == 4'd0)));
        w_dx      = (fmt == 2'd1) && ad;
        case (fmt)
            2'd1:    w_word0 = {opcode, src, ad, bw, as, dst};
            2'd2:    w_word0 = {6'b000100, op2, bw, as, dst};
            2'd3:    w_word0 = {3'b001, cond, offset};
            default: w_word0 = 16'h0000;
        endcase
        w_req_ready = (r_state == S_IDLE) && !load_addr;
        w_accept    = req_valid && w_req_ready;
        w_accept_ok = w_accept && !w_illegal;
    end

    // Next-state, final-write detection and next write data
    always_comb begin
        w_state_next = r_state;
        w_final      = 1'b0;
        w_mdb_next   = r_mdb;
        case (r_state)
            S_IDLE: begin
                if (w_accept_ok) begin
                    w_state_next = S_INSTR;
                    w_mdb_next   = w_word0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_INSTR: begin
                if (mem_ready) begin
                    if (r_sx) begin
                        w_state_next = S_SRCX;
                        w_mdb_next   = r_src_ext;
                    end else if (r_dx) begin
                        w_state_next = S_DSTX;
                        w_mdb_next   = r_dst_ext;
                    end else begin
                        w_state_next = S_IDLE;
                        w_final      = 1'b1;
                    end
                end else begin
                    w_state_next = S_INSTR;
                end
            end
            S_SRCX: begin
                if (mem_ready) begin
                    if (r_dx) begin
                        w_state_next = S_DSTX;
                        w_mdb_next   = r_dst_ext;
                    end else begin
                        w_state_next = S_IDLE;
                        w_final      = 1'b1;
                    end
                end else begin
                    w_state_next = S_SRCX;
                end
            end
            S_DSTX: begin
                if (mem_ready) begin
                    w_state_next = S_IDLE;
                    w_final      = 1'b1;
                end else begin
                    w_state_next = S_DSTX;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Address, write port, request latches and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= START_ADDR & 16'hFFFE;
            r_mdb     <= 16'h0000;
            r_mw      <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_nwords  <= 2'd0;
            r_sx      <= 1'b0;
            r_dx      <= 1'b0;
            r_src_ext <= 16'h0000;
            r_dst_ext <= 16'h0000;
        end else begin
            r_mdb  <= w_mdb_next;
            r_mw   <= (w_state_next != S_IDLE);
            r_done <= w_final;
            r_err  <= w_accept && w_illegal;
            if ((r_state == S_IDLE) && load_addr) begin
                r_addr <= addr_in & 16'hFFFE;
            end else if (r_mw && mem_ready) begin
                r_addr <= r_addr + 16'd2;
            end
            if (w_accept_ok) begin
                r_sx      <= w_sx;
                r_dx      <= w_dx;
                r_src_ext <= src_ext;
                r_dst_ext <= dst_ext;
                r_nwords  <= 2'd1 + {1'b0, w_sx} + {1'b0, w_dx};
            end
        end
    end

    assign req_ready = w_req_ready;
    assign MAB_out   = r_addr;
    assign MDB_in    = r_mdb;
    assign MW        = r_mw;
    assign nwords    = r_nwords;
    assign done      = r_done;
    assign err       = r_err;

endmodule
